// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blink_pkg
// Description : Shared elaboration-time helpers for clock dividers.
//               Provides a minimum-width log2 and a 64-bit half-period.
// Revision    : 1.0 - initial release
// ============================================================================
package blink_pkg;

    // Returns max(1, ceil(log2(n))). This is the smallest counter width that
    // can hold the values 0 to n-1, and it is never zero.
    function automatic int unsigned clog2_min1(input longint unsigned n);
        int unsigned     w;
        longint unsigned v;
        w = 0;
        v = 64'd1;
        while (v < n) begin
            v = v << 1;
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Half-period in clock cycles. The multiply is done in 64 bits so that
    // high clock rates combined with long durations cannot overflow 32 bits.
    function automatic longint unsigned half_period(input longint unsigned freq,
                                                    input longint unsigned secs);
        return freq * secs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blink_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : blink_tick_divider
// Description : Modulo-N counter that issues a one-cycle tick on count N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_tick_divider
    import blink_pkg::*;
#(
    parameter longint unsigned N = 64'd2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned       c_w    = clog2_min1(N);
    localparam logic [c_w-1:0]    c_last = c_w'(N - 64'd1);

    logic [c_w-1:0] r_count;
    logic           w_tick;

    assign w_tick = (r_count == c_last);
    assign tick_o = w_tick;

    // Count 0..N-1. The only wrap is the explicit return to zero at N-1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/blink.sv
`default_nettype none
// ============================================================================
// Module      : blink
// Description : Free-running LED blinker. Toggles a registered LED output
//               every FREQ*SECS clock cycles, giving a 50% duty square wave.
// Revision    : 1.0 - initial release
// ============================================================================
module blink
    import blink_pkg::*;
#(
    parameter longint unsigned FREQ = 64'd25_000_000,
    parameter longint unsigned SECS = 64'd1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic led_o
);

    localparam longint unsigned c_n      = half_period(FREQ, SECS);
    // Keeps the divider legal while the zero-length check below aborts.
    localparam longint unsigned c_n_safe = (c_n == 64'd0) ? 64'd1 : c_n;
    localparam int unsigned     c_w      = clog2_min1(c_n_safe);

    // A zero half-period has no meaningful behaviour, so refuse to build it.
    generate
        if (c_n == 64'd0) begin : g_bad_param
            $fatal(1, "blink: FREQ=%0d SECS=%0d gives a zero half-period", FREQ, SECS);
        end
    endgenerate

    logic w_tick;
    logic r_led;

    blink_tick_divider #(
        .N (c_n_safe)
    ) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (w_tick)
    );

    // Flip the LED once per half-period. Reset wins over a pending toggle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_led <= 1'b0;
        end else if (w_tick) begin
            r_led <= ~r_led;
        end
    end

    assign led_o = r_led;

endmodule
`default_nettype wire

// File: tb/tb_blink.sv
`default_nettype none
// ============================================================================
// Module      : tb_blink
// Description : Directed self-checking bench for blink at several half-periods
//               (N = 10, 1, 6 and a >32-bit N), including mid-count reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blink;

    logic clk;
    logic rst;
    logic led10;
    logic led1;
    logic led6;
    logic ledbig;

    int n_asserts = 0;
    int n_fail    = 0;

    blink #(.FREQ(64'd10),          .SECS(64'd1))  u10  (.clk_i(clk), .rst_i(rst), .led_o(led10));
    blink #(.FREQ(64'd1),           .SECS(64'd1))  u1   (.clk_i(clk), .rst_i(rst), .led_o(led1));
    blink #(.FREQ(64'd3),           .SECS(64'd2))  u6   (.clk_i(clk), .rst_i(rst), .led_o(led6));
    blink #(.FREQ(64'd100_000_000), .SECS(64'd50)) ubig (.clk_i(clk), .rst_i(rst), .led_o(ledbig));

    // Clock generator.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point: count it, assert it, report on failure.
    task automatic check(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived LED level at edge k after release for half-period n.
    function automatic logic exp_led(input int k, input int n);
        return ((k / n) % 2) == 1;
    endfunction

    // Directed sequence.
    initial begin
        rst = 1'b1;
        repeat (3) step();

        check("rst_led10",  led10,  1'b0);
        check("rst_led1",   led1,   1'b0);
        check("rst_led6",   led6,   1'b0);
        check("rst_ledbig", ledbig, 1'b0);

        // Big-N elaboration: width 33 and untruncated product.
        n_asserts++;
        assert (ubig.c_w == 33) else begin
            n_fail++;
            $error("FAIL big_width: observed %0d expected 33", ubig.c_w);
        end
        n_asserts++;
        assert (ubig.c_n == 64'd5_000_000_000) else begin
            n_fail++;
            $error("FAIL big_n: observed %0d expected 5000000000", ubig.c_n);
        end

        // Free run: 100 edges = 5 full periods at N=10.
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            check($sformatf("n10_e%0d", k), led10, exp_led(k, 10));
            check($sformatf("n1_e%0d",  k), led1,  exp_led(k, 1));
            check($sformatf("n6_e%0d",  k), led6,  exp_led(k, 6));
            check($sformatf("big_e%0d", k), ledbig, 1'b0);
            check($sformatf("n6_cnt_e%0d", k), (u6.u_div.r_count >= 3'd6), 1'b0);
        end

        // Fresh start, then reset at edge 15 while the N=10 LED is high.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("pre_n10_e%0d", k), led10, exp_led(k, 10));
        end
        check("led_high_before_rst", led10, 1'b1);
        rst = 1'b1;
        step();
        check("mid_rst_led10", led10, 1'b0);
        check("mid_rst_led1",  led1,  1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("post_n10_e%0d", k), led10, exp_led(k, 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
